seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 26 ++
 rtl/seq_chunk_add.sv | 38 +++
 rtl/seq_chunk_adder.sv | 143 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// ============================================================================
// Module  : seq_chunk_adder_pkg
// Brief   : FSM encoding and default geometry for the chunked serial adder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package seq_chunk_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CHUNK = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Chunk index width; a single-chunk adder still needs a 1-bit index.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chunk_add.sv
// ============================================================================
// Module  : chunk_add
// Brief   : CHUNK-bit ripple-carry adder, also exposing the carry into its MSB.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module chunk_add
   import seq_chunk_adder_pkg::*;
#(
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] w_c;

   always_comb begin
      w_c    = '0;
      sum    = '0;
      w_c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = w_c[CHUNK];
   assign c_msb = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// ============================================================================
// Module  : seq_chunk_adder
// Brief   : Adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
//           Define SEQ_CHUNK_ADDER_SUB_EN to add the sub (X-Y) port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int            NCHUNK = WIDTH / CHUNK;
   localparam int            KW     = idx_width(NCHUNK);
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_yp;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic [WIDTH-1:0] w_yp_in;
   logic             w_cin_in;
   logic [CHUNK-1:0] w_a;
   logic [CHUNK-1:0] w_b;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic             w_c_msb;
   logic             w_last;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   // Subtraction is X + ~Y + 1; a final carry of 1 means no borrow.
   assign w_yp_in  = sub ? ~Y : Y;
   assign w_cin_in = sub;
`else
   assign w_yp_in  = Y;
   assign w_cin_in = 1'b0;
`endif

   assign w_a    = r_x[int'(r_k)*CHUNK +: CHUNK];
   assign w_b    = r_yp[int'(r_k)*CHUNK +: CHUNK];
   assign w_last = (r_k == K_LAST);

   chunk_add #(
      .CHUNK (CHUNK)
   ) u_chunk_add (
      .a     (w_a),
      .b     (w_b),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_cout),
      .c_msb (w_c_msb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_yp    <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x     <= X;
                  r_yp    <= w_yp_in;
                  r_carry <= w_cin_in;
                  r_k     <= '0;
                  r_s     <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
               end
            end
            RUN: begin
               r_s[int'(r_k)*CHUNK +: CHUNK] <= w_sum;
               r_carry                       <= w_cout;
               // The top chunk's carry leaves only via cout; it never re-enters chunk 0.
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= w_c_msb ^ w_cout;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign S         = r_s;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// ============================================================================
// Module  : tb_seq_chunk_adder
// Brief   : Directed self-checking bench for seq_chunk_adder (WIDTH=32, CHUNK=8).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_seq_chunk_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] X;
   logic [31:0] Y;
   logic        sub;
   logic [31:0] S;
   logic        cout;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_chunk_adder #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Y         (Y),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      .sub       (sub),
`endif
      .S         (S),
      .cout      (cout),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic [31:0] x, input logic [31:0] y, input logic s);
      X        = x;
      Y        = y;
      sub      = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_txn;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      X         = '0;
      Y         = '0;
      sub       = 1'b0;
      #12;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (S !== 32'h0) $display("FAIL reset S: got %h expected 00000000", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b0) $display("FAIL reset cout: got %b expected 0", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset ovf: got %b expected 0", ovf); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_carry_wrap;
      int lat;
      start_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done(lat);
      chk_cnt++; if (lat !== 4) $display("FAIL wrap latency: got %0d expected 4", lat); else pass_cnt++;
      chk_cnt++; if (S !== 32'h0) $display("FAIL wrap S: got %h expected 00000000", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b1) $display("FAIL wrap cout: got %b expected 1", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL wrap ovf: got %b expected 0", ovf); else pass_cnt++;
      finish_txn();
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL wrap release out_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL wrap release in_ready: got %b expected 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_overflow;
      int lat;
      start_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done(lat);
      chk_cnt++; if (S !== 32'h8000_0000) $display("FAIL ovf_pos S: got %h expected 80000000", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b0) $display("FAIL ovf_pos cout: got %b expected 0", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_pos ovf: got %b expected 1", ovf); else pass_cnt++;
      finish_txn();
      start_txn(32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_done(lat);
      chk_cnt++; if (S !== 32'h0) $display("FAIL ovf_neg S: got %h expected 00000000", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b1) $display("FAIL ovf_neg cout: got %b expected 1", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_neg ovf: got %b expected 1", ovf); else pass_cnt++;
      finish_txn();
   endtask

   task automatic test_hold;
      int lat;
      start_txn(32'h1234_5678, 32'h1111_1111, 1'b0);
      X = 32'hFFFF_FFFF;
      Y = 32'hFFFF_FFFF;
      wait_done(lat);
      chk_cnt++; if (lat !== 4) $display("FAIL hold latency: got %0d expected 4", lat); else pass_cnt++;
      chk_cnt++; if (S !== 32'h2345_6789) $display("FAIL hold S: got %h expected 23456789", S); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++; if (S !== 32'h2345_6789) $display("FAIL hold S cycle %0d: got %h expected 23456789", i, S); else pass_cnt++;
         chk_cnt++; if (out_valid !== 1'b1) $display("FAIL hold out_valid cycle %0d: got %b expected 1", i, out_valid); else pass_cnt++;
         chk_cnt++; if (in_ready !== 1'b0) $display("FAIL hold in_ready cycle %0d: got %b expected 0", i, in_ready); else pass_cnt++;
      end
      X        = 32'h0000_0001;
      Y        = 32'h0000_0001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_cnt++; if (S !== 32'h2345_6789) $display("FAIL hold in_valid ignored S: got %h expected 23456789", S); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL hold in_valid ignored out_valid: got %b expected 1", out_valid); else pass_cnt++;
      finish_txn();
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL hold release in_ready: got %b expected 1", in_ready); else pass_cnt++;
      tick();
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL hold stays idle in_ready: got %b expected 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_reset_abort;
      int lat;
      start_txn(32'h0101_0101, 32'h0101_0101, 1'b0);
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (S !== 32'h0) $display("FAIL abort S: got %h expected 00000000", S); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort out_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL abort in_ready: got %b expected 1", in_ready); else pass_cnt++;
      chk_cnt++; if ({cout, ovf} !== 2'b00) $display("FAIL abort cout/ovf: got %b expected 00", {cout, ovf}); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      start_txn(32'd5, 32'd3, 1'b0);
      wait_done(lat);
      chk_cnt++; if (lat !== 4) $display("FAIL abort restart latency: got %0d expected 4", lat); else pass_cnt++;
      chk_cnt++; if (S !== 32'd8) $display("FAIL abort restart S: got %h expected 00000008", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b0) $display("FAIL abort restart cout: got %b expected 0", cout); else pass_cnt++;
      finish_txn();
   endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   task automatic test_sub;
      int lat;
      start_txn(32'd5, 32'd7, 1'b1);
      wait_done(lat);
      chk_cnt++; if (S !== 32'hFFFF_FFFE) $display("FAIL sub 5-7 S: got %h expected fffffffe", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b0) $display("FAIL sub 5-7 cout: got %b expected 0", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL sub 5-7 ovf: got %b expected 0", ovf); else pass_cnt++;
      finish_txn();
      start_txn(32'd7, 32'd5, 1'b1);
      wait_done(lat);
      chk_cnt++; if (S !== 32'd2) $display("FAIL sub 7-5 S: got %h expected 00000002", S); else pass_cnt++;
      chk_cnt++; if (cout !== 1'b1) $display("FAIL sub 7-5 cout: got %b expected 1", cout); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL sub 7-5 ovf: got %b expected 0", ovf); else pass_cnt++;
      finish_txn();
   endtask
`endif

   task automatic test_back_to_back;
      logic [31:0] x, y, yp;
      logic [32:0] exp_res;
      logic        s, exp_ovf;
      int          prev, waited;
      prev      = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int n = 0; n < 8; n++) begin
         waited = 0;
         while (in_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
         end
         x = $urandom;
         y = $urandom;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         yp      = s ? ~y : y;
         exp_res = {1'b0, x} + {1'b0, yp} + {32'd0, s};
         exp_ovf = (x[31] == yp[31]) && (exp_res[31] != x[31]);
         X   = x;
         Y   = y;
         sub = s;
         tick();
         waited = 0;
         while (out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
         end
         chk_cnt++; if ({cout, S} !== exp_res) $display("FAIL b2b %0d result: got %h expected %h", n, {cout, S}, exp_res); else pass_cnt++;
         chk_cnt++; if (ovf !== exp_ovf) $display("FAIL b2b %0d ovf: got %b expected %b", n, ovf, exp_ovf); else pass_cnt++;
         if (n > 0) begin
            chk_cnt++; if (cyc - prev !== 6) $display("FAIL b2b %0d spacing: got %0d expected 6", n, cyc - prev); else pass_cnt++;
         end
         prev = cyc;
      end
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_carry_wrap();
      test_overflow();
      test_hold();
      test_reset_abort();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      test_sub();
`endif
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
